uart_cmd_rx: RTL and testbench

//   RS-232 receiver plus command decoder; upstream control stage of the two-channel ADC/TX chain.

---
 rtl/uart_cmd_rx_if.sv | 31 +++
 rtl/uart_cmd_rx.sv | 140 ++++++++++++++
 tb/tb_uart_cmd_rx.sv | 286 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_cmd_rx_if.sv
// Serial command receiver bus.
//   rx_i   : serial line, idle high, asynchronous to the receiver clock
//   baud_i : bit period minus one, in clocks
//   psel_i : 1 = even parity bit follows the data bits
//   d_o    : last correctly received byte
//   rdy_o / perr_o / ferr_o / sta_o : one-cycle event pulses
//   cont_o : continuous-acquisition level
// master = line/config driver (host side), slave = receiver.
interface uart_cmd_rx_if #(
   parameter int Width = 15
);
   logic             rx_i;
   logic [Width-1:0] baud_i;
   logic             psel_i;
   logic [7:0]       d_o;
   logic             rdy_o;
   logic             perr_o;
   logic             ferr_o;
   logic             sta_o;
   logic             cont_o;

   modport master (
      output rx_i, baud_i, psel_i,
      input  d_o, rdy_o, perr_o, ferr_o, sta_o, cont_o
   );

   modport slave (
      input  rx_i, baud_i, psel_i,
      output d_o, rdy_o, perr_o, ferr_o, sta_o, cont_o
   );
endinterface

// File: rtl/uart_cmd_rx.sv
// RS-232 receiver with single-byte command decoder.
// Frame: 1 start, 8 data LSB-first, optional even parity, 1 stop.
// Ports:
//   clk_i : system clock
//   rst_i : asynchronous active-high reset
//   bus   : uart_cmd_rx_if slave (rx line, baud/parity config, decoded outputs)
// A clean frame updates d_o and pulses rdy_o; 'S' also pulses sta_o, 'C'/'P'
// set/clear cont_o. Parity and framing errors pulse perr_o/ferr_o and drop the byte.
module uart_cmd_rx #(
   parameter int         Width   = 15,
   parameter logic [7:0] CMD_SGL = 8'h53,
   parameter logic [7:0] CMD_CON = 8'h43,
   parameter logic [7:0] CMD_STP = 8'h50
) (
   input logic          clk_i,
   input logic          rst_i,
   uart_cmd_rx_if.slave bus
);

   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

   state_t           state_q, state_d;
   logic             rx_meta_q, rxs_q;
   logic [Width-1:0] cnt_q, cnt_d;
   logic [2:0]       bitn_q, bitn_d;
   logic [7:0]       sr_q, sr_d;
   logic             perr_q, perr_d;    // parity result held from PARITY to STOP
   logic [7:0]       d_q, d_d;
   logic             rdy_q, rdy_d;
   logic             perr_o_q, perr_o_d;
   logic             ferr_q, ferr_d;
   logic             sta_q, sta_d;
   logic             cont_q, cont_d;

   logic             at_end;

   assign at_end = (cnt_q == bus.baud_i);

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q + Width'(1);
      bitn_d   = bitn_q;
      sr_d     = sr_q;
      perr_d   = perr_q;
      d_d      = d_q;
      cont_d   = cont_q;
      rdy_d    = 1'b0;
      perr_o_d = 1'b0;
      ferr_d   = 1'b0;
      sta_d    = 1'b0;
      unique case (state_q)
         IDLE: begin
            cnt_d = '0;
            if (!rxs_q) state_d = START;
         end
         START: begin
            // Centre of the start bit; a high line here was a glitch.
            if (cnt_q == (bus.baud_i >> 1)) begin
               cnt_d  = '0;
               bitn_d = '0;
               perr_d = 1'b0;
               state_d = rxs_q ? IDLE : DATA;
            end
         end
         DATA: begin
            if (at_end) begin
               cnt_d  = '0;
               sr_d   = {rxs_q, sr_q[7:1]};
               bitn_d = bitn_q + 3'd1;
               if (bitn_q == 3'd7) state_d = bus.psel_i ? PARITY : STOP;
            end
         end
         PARITY: begin
            if (at_end) begin
               cnt_d   = '0;
               perr_d  = (^sr_q) ^ rxs_q;
               state_d = STOP;
            end
         end
         STOP: begin
            if (at_end) begin
               cnt_d   = '0;
               state_d = IDLE;
               if (!rxs_q) begin
                  ferr_d = 1'b1;
               end else if (perr_q) begin
                  perr_o_d = 1'b1;
               end else begin
                  d_d   = sr_q;
                  rdy_d = 1'b1;
                  if (sr_q == CMD_SGL) sta_d  = 1'b1;
                  if (sr_q == CMD_CON) cont_d = 1'b1;
                  if (sr_q == CMD_STP) cont_d = 1'b0;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q   <= IDLE;
         rx_meta_q <= 1'b1;
         rxs_q     <= 1'b1;
         cnt_q     <= '0;
         bitn_q    <= '0;
         sr_q      <= '0;
         perr_q    <= 1'b0;
         d_q       <= '0;
         rdy_q     <= 1'b0;
         perr_o_q  <= 1'b0;
         ferr_q    <= 1'b0;
         sta_q     <= 1'b0;
         cont_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         rx_meta_q <= bus.rx_i;
         rxs_q     <= rx_meta_q;
         cnt_q     <= cnt_d;
         bitn_q    <= bitn_d;
         sr_q      <= sr_d;
         perr_q    <= perr_d;
         d_q       <= d_d;
         rdy_q     <= rdy_d;
         perr_o_q  <= perr_o_d;
         ferr_q    <= ferr_d;
         sta_q     <= sta_d;
         cont_q    <= cont_d;
      end
   end

   assign bus.d_o    = d_q;
   assign bus.rdy_o  = rdy_q;
   assign bus.perr_o = perr_o_q;
   assign bus.ferr_o = ferr_q;
   assign bus.sta_o  = sta_q;
   assign bus.cont_o = cont_q;

endmodule

// File: tb/tb_uart_cmd_rx.sv
`timescale 1ns/1ps
module tb_uart_cmd_rx;

   localparam int BAUD = 31;           // short bit period keeps the run small
   localparam int P    = BAUD + 1;     // clocks per bit

   typedef struct {
      logic       rdy, sta, perr, ferr;
      logic [7:0] d;
      logic       cont;
   } ev_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   uart_cmd_rx_if #(.Width(15)) bus ();
   uart_cmd_rx dut (.clk_i(clk), .rst_i(rst), .bus(bus));

   ev_t        sb[$];
   int         n_cmp = 0;
   int         n_err = 0;
   int         ev_cnt = 0;
   logic [7:0] m_d = 8'h00;
   logic       m_cont = 1'b0;

   // Scoreboard monitor: every cycle with any event pulse consumes one expectation.
   always @(negedge clk) begin
      if (bus.rdy_o || bus.sta_o || bus.perr_o || bus.ferr_o) begin
         ev_t e;
         ev_cnt++;
         n_cmp++;
         if (sb.size() == 0) begin
            n_err++;
            $display("FAIL unexpected_event: got rdy=%b sta=%b perr=%b ferr=%b d=%h, required none",
                     bus.rdy_o, bus.sta_o, bus.perr_o, bus.ferr_o, bus.d_o);
         end else begin
            e = sb.pop_front();
            if ({bus.rdy_o, bus.sta_o, bus.perr_o, bus.ferr_o, bus.d_o, bus.cont_o} !==
                {e.rdy, e.sta, e.perr, e.ferr, e.d, e.cont}) begin
               n_err++;
               $display("FAIL event: got rdy=%b sta=%b perr=%b ferr=%b d=%h cont=%b, required rdy=%b sta=%b perr=%b ferr=%b d=%h cont=%b",
                        bus.rdy_o, bus.sta_o, bus.perr_o, bus.ferr_o, bus.d_o, bus.cont_o,
                        e.rdy, e.sta, e.perr, e.ferr, e.d, e.cont);
            end
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   // Reference model of one received frame.
   task automatic expect_frame(input logic [7:0] b, input logic par_ok, input logic stop_ok);
      ev_t e;
      e = '{rdy: 1'b0, sta: 1'b0, perr: 1'b0, ferr: 1'b0, d: m_d, cont: m_cont};
      if (!stop_ok)     e.ferr = 1'b1;
      else if (!par_ok) e.perr = 1'b1;
      else begin
         m_d = b;
         if (b == 8'h43) m_cont = 1'b1;
         if (b == 8'h50) m_cont = 1'b0;
         e.rdy  = 1'b1;
         e.sta  = (b == 8'h53);
         e.d    = m_d;
         e.cont = m_cont;
      end
      sb.push_back(e);
   endtask

   task automatic drive_bit(input logic b, input int clks);
      bus.rx_i = b;
      repeat (clks) @(negedge clk);
   endtask

   // stop_lo > 0 holds the stop bit low for that many clocks, then high.
   task automatic send_frame(input logic [7:0] b, input logic par_en, input logic par, input int stop_lo);
      drive_bit(1'b0, P);
      for (int i = 0; i < 8; i++) drive_bit(b[i], P);
      if (par_en) drive_bit(par, P);
      if (stop_lo > 0) begin
         drive_bit(1'b0, stop_lo);
         drive_bit(1'b1, P - stop_lo);
      end else begin
         drive_bit(1'b1, P);
      end
   endtask

   task automatic wait_drain();
      int t;
      t = 0;
      while (sb.size() != 0 && t < 20 * P) begin
         @(negedge clk);
         t++;
      end
      repeat (4) @(negedge clk);
      n_cmp++;
      if (sb.size() != 0) begin
         n_err++;
         $display("FAIL drain: %0d expected events outstanding, required 0", sb.size());
         sb.delete();
      end
   endtask

   task automatic test_reset();
      bus.rx_i = 1'b1; bus.baud_i = 15'(BAUD); bus.psel_i = 1'b0;
      rst = 1'b1;
      repeat (3) @(negedge clk);
      #1;
      n_cmp++;
      if ({bus.d_o, bus.rdy_o, bus.perr_o, bus.ferr_o, bus.sta_o, bus.cont_o} !== 13'h0) begin
         n_err++;
         $display("FAIL reset_outputs: got d=%h rdy=%b perr=%b ferr=%b sta=%b cont=%b, required all 0",
                  bus.d_o, bus.rdy_o, bus.perr_o, bus.ferr_o, bus.sta_o, bus.cont_o);
      end
      @(negedge clk);
      rst = 1'b0;
      repeat (4) @(negedge clk);
      n_cmp++;
      if ({bus.rdy_o, bus.sta_o, bus.cont_o} !== 3'b000) begin
         n_err++;
         $display("FAIL idle_after_reset: got rdy=%b sta=%b cont=%b, required 000",
                  bus.rdy_o, bus.sta_o, bus.cont_o);
      end
   endtask

   task automatic test_single();
      bus.psel_i = 1'b0;
      expect_frame(8'h53, 1'b1, 1'b1);
      send_frame(8'h53, 1'b0, 1'b0, 0);
      wait_drain();
      n_cmp++;
      if ({bus.d_o, bus.sta_o, bus.cont_o} !== {8'h53, 1'b0, 1'b0}) begin
         n_err++;
         $display("FAIL single_after: got d=%h sta=%b cont=%b, required d=53 sta=0 cont=0",
                  bus.d_o, bus.sta_o, bus.cont_o);
      end
   endtask

   task automatic test_cont();
      bus.psel_i = 1'b1;
      expect_frame(8'h43, 1'b1, 1'b1);
      send_frame(8'h43, 1'b1, 1'b1, 0);          // 'C' has three ones -> parity 1
      wait_drain();
      n_cmp++;
      if (bus.cont_o !== 1'b1) begin
         n_err++;
         $display("FAIL cont_set: got cont=%b, required 1", bus.cont_o);
      end
      expect_frame(8'h50, 1'b1, 1'b1);
      send_frame(8'h50, 1'b1, 1'b0, 0);          // 'P' has two ones -> parity 0
      wait_drain();
      n_cmp++;
      if ({bus.cont_o, bus.d_o} !== {1'b0, 8'h50}) begin
         n_err++;
         $display("FAIL cont_clear: got cont=%b d=%h, required cont=0 d=50", bus.cont_o, bus.d_o);
      end
   endtask

   task automatic test_perr();
      bus.psel_i = 1'b1;
      // 'S' has four ones, so its even parity bit is 0; send 1 to force a mismatch.
      expect_frame(8'h53, 1'b0, 1'b1);
      send_frame(8'h53, 1'b1, 1'b1, 0);
      wait_drain();
      n_cmp++;
      if (bus.d_o !== 8'h50) begin
         n_err++;
         $display("FAIL perr_d_kept: got d=%h, required 50", bus.d_o);
      end
   endtask

   task automatic test_ferr();
      int ev0;
      bus.psel_i = 1'b0;
      // Stop bit low for 3/4 period: sampled low, and the re-armed start
      // centre sees the line back high, so only one ferr results.
      expect_frame(8'hA5, 1'b1, 1'b0);
      send_frame(8'hA5, 1'b0, 1'b0, (3 * P) / 4);
      wait_drain();
      ev0 = ev_cnt;
      n_cmp++;
      if (bus.d_o !== 8'h50) begin
         n_err++;
         $display("FAIL ferr_d_kept: got d=%h, required 50", bus.d_o);
      end
      repeat (2 * P) @(negedge clk);
      n_cmp++;
      if (ev_cnt !== ev0) begin
         n_err++;
         $display("FAIL ferr_rearm_quiet: got %0d extra events, required 0", ev_cnt - ev0);
      end
      expect_frame(8'h41, 1'b1, 1'b1);
      send_frame(8'h41, 1'b0, 1'b0, 0);
      wait_drain();
      n_cmp++;
      if (bus.d_o !== 8'h41) begin
         n_err++;
         $display("FAIL ferr_recover: got d=%h, required 41", bus.d_o);
      end
   endtask

   task automatic test_glitch();
      int ev0;
      ev0 = ev_cnt;
      drive_bit(1'b0, (3 * P) / 10);
      drive_bit(1'b1, 3 * P);
      n_cmp++;
      if (ev_cnt !== ev0) begin
         n_err++;
         $display("FAIL glitch_quiet: got %0d events, required 0", ev_cnt - ev0);
      end
      expect_frame(8'h5A, 1'b1, 1'b1);
      send_frame(8'h5A, 1'b0, 1'b0, 0);
      wait_drain();
   endtask

   task automatic test_back_to_back();
      logic [7:0] seq [4];
      seq = '{8'h43, 8'h53, 8'h7E, 8'h50};
      bus.psel_i = 1'b1;
      for (int i = 0; i < 4; i++) begin
         expect_frame(seq[i], 1'b1, 1'b1);
         send_frame(seq[i], 1'b1, ^seq[i], 0);
      end
      wait_drain();
      n_cmp++;
      if ({bus.d_o, bus.cont_o} !== {8'h50, 1'b0}) begin
         n_err++;
         $display("FAIL b2b_final: got d=%h cont=%b, required d=50 cont=0", bus.d_o, bus.cont_o);
      end
   endtask

   task automatic test_reset_mid();
      logic [7:0] s;
      int         ev0;
      s = 8'h53;
      bus.psel_i = 1'b0;
      expect_frame(8'h43, 1'b1, 1'b1);           // cont=1 so the reset has something to clear
      send_frame(8'h43, 1'b0, 1'b0, 0);
      wait_drain();
      drive_bit(1'b0, P);
      for (int i = 0; i < 4; i++) drive_bit(s[i], P);
      drive_bit(s[4], P / 2);
      rst = 1'b1;
      #1;
      n_cmp++;
      if ({bus.d_o, bus.rdy_o, bus.perr_o, bus.ferr_o, bus.sta_o, bus.cont_o} !== 13'h0) begin
         n_err++;
         $display("FAIL midframe_reset: got d=%h rdy=%b perr=%b ferr=%b sta=%b cont=%b, required all 0",
                  bus.d_o, bus.rdy_o, bus.perr_o, bus.ferr_o, bus.sta_o, bus.cont_o);
      end
      m_d = 8'h00;
      m_cont = 1'b0;
      bus.rx_i = 1'b1;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      ev0 = ev_cnt;
      repeat (2 * P) @(negedge clk);
      n_cmp++;
      if (ev_cnt !== ev0) begin
         n_err++;
         $display("FAIL midframe_quiet: got %0d events, required 0", ev_cnt - ev0);
      end
      expect_frame(8'h53, 1'b1, 1'b1);
      send_frame(8'h53, 1'b0, 1'b0, 0);
      wait_drain();
   endtask

   initial begin
      test_reset();
      test_single();
      test_cont();
      test_perr();
      test_ferr();
      test_glitch();
      test_back_to_back();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
